// File: rtl/lab76_add_sub_issuer.sv
// lab76_add_sub_issuer
// Issue/collect wrapper around the combinational 16-bit add/sub core.
// Requests are registered onto the core ports and held there. On the
// following edge, the core's result is captured into a small response FIFO,
// along with the carry, zero and signed-overflow flags and the request tag.
// The FIFO is drained over a valid/ready handshake.

module lab76_add_sub_issuer #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk_in,
    input  logic         rst_n_in,

    input  logic         req_valid_in,
    output logic         req_ready_out,
    input  logic [N-1:0] req_a_in,
    input  logic [N-1:0] req_b_in,
    input  logic         req_op_in,
    input  logic [3:0]   req_tag_in,

    output logic [N-1:0] core_a_out,
    output logic [N-1:0] core_b_out,
    output logic         core_op_out,
    input  logic [N-1:0] core_result_in,
    input  logic         core_carry_in,

    output logic         rsp_valid_out,
    input  logic         rsp_ready_in,
    output logic [N-1:0] rsp_result_out,
    output logic         rsp_carry_out,
    output logic         rsp_zero_out,
    output logic         rsp_ovf_out,
    output logic [3:0]   rsp_tag_out,

    output logic         busy_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [N-1:0] result;
        logic         carry;
        logic         zero;
        logic         ovf;
        logic [3:0]   tag;
    } rsp_entry_t;

    // Issue stage: operands are held here and drive the core directly.
    logic         iss_v;
    logic [N-1:0] iss_a;
    logic [N-1:0] iss_b;
    logic         iss_op;
    logic [3:0]   iss_tag;

    // Response FIFO storage and bookkeeping.
    rsp_entry_t       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       space;
    logic       push;
    logic       accept;
    rsp_entry_t new_entry;
    rsp_entry_t head;

    // Handshake decisions. A pop frees a slot on the same edge, so a full FIFO
    // can still take the issue stage's result when the consumer is draining.
    always_comb begin
        fifo_empty    = (count == '0);
        fifo_full     = (count == CNT_W'(DEPTH));
        pop           = !fifo_empty && rsp_ready_in;
        space         = !fifo_full || pop;
        push          = iss_v && space;
        req_ready_out = !iss_v || space;
        accept        = req_valid_in && req_ready_out;
        busy_out      = iss_v || !fifo_empty;
    end

    // Build the response entry from the core output. Overflow is computed
    // from the registered operands, and the sign rule flips for subtraction.
    always_comb begin
        new_entry        = '0;
        new_entry.result = core_result_in;
        new_entry.carry  = core_carry_in;
        new_entry.zero   = (core_result_in == '0);
        new_entry.tag    = iss_tag;
        if (iss_op) begin
            new_entry.ovf = (iss_a[N-1] != iss_b[N-1]) &&
                            (core_result_in[N-1] != iss_a[N-1]);
        end else begin
            new_entry.ovf = (iss_a[N-1] == iss_b[N-1]) &&
                            (core_result_in[N-1] != iss_a[N-1]);
        end
    end

    // Issue register. A new request may replace a result that is being
    // captured on the same edge. Otherwise the stage empties after its capture.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            iss_v   <= 1'b0;
            iss_a   <= '0;
            iss_b   <= '0;
            iss_op  <= 1'b0;
            iss_tag <= '0;
        end else if (accept) begin
            iss_v   <= 1'b1;
            iss_a   <= req_a_in;
            iss_b   <= req_b_in;
            iss_op  <= req_op_in;
            iss_tag <= req_tag_in;
        end else if (push) begin
            iss_v   <= 1'b0;
        end
    end

    // FIFO storage and pointers. The pointers wrap naturally because DEPTH is
    // a power of two.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= new_entry;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy count. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head of the FIFO. Outputs are forced to zero while the FIFO is empty so
    // that stale entries never show on the response bus.
    always_comb begin
        head           = fifo_mem[rd_ptr];
        rsp_valid_out  = !fifo_empty;
        rsp_result_out = '0;
        rsp_carry_out  = 1'b0;
        rsp_zero_out   = 1'b0;
        rsp_ovf_out    = 1'b0;
        rsp_tag_out    = '0;
        if (!fifo_empty) begin
            rsp_result_out = head.result;
            rsp_carry_out  = head.carry;
            rsp_zero_out   = head.zero;
            rsp_ovf_out    = head.ovf;
            rsp_tag_out    = head.tag;
        end
    end

    // Core ports follow the issue register. They keep their last operands
    // after the capture.
    always_comb begin
        core_a_out  = iss_a;
        core_b_out  = iss_b;
        core_op_out = iss_op;
    end

endmodule

// File: tb/tb_lab76_add_sub_issuer.sv
// Testbench for lab76_add_sub_issuer.
// Models the combinational add/sub core and checks every response against a
// scoreboard. Directed vectors, back-pressure, streaming and reset sequences
// are applied.

module tb_lab76_add_sub_issuer;

    logic        clk_in;
    logic        rst_n_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [15:0] req_a_in;
    logic [15:0] req_b_in;
    logic        req_op_in;
    logic [3:0]  req_tag_in;
    logic [15:0] core_a_out;
    logic [15:0] core_b_out;
    logic        core_op_out;
    logic [15:0] core_result_in;
    logic        core_carry_in;
    logic        rsp_valid_out;
    logic        rsp_ready_in;
    logic [15:0] rsp_result_out;
    logic        rsp_carry_out;
    logic        rsp_zero_out;
    logic        rsp_ovf_out;
    logic [3:0]  rsp_tag_out;
    logic        busy_out;

    int checks;
    int passed;

    logic [22:0] sb[$];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [3:0]  tag;
        logic [15:0] exp_result;
        logic        exp_carry;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [6];

    lab76_add_sub_issuer #(.N(16), .DEPTH(4)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_a_in       (req_a_in),
        .req_b_in       (req_b_in),
        .req_op_in      (req_op_in),
        .req_tag_in     (req_tag_in),
        .core_a_out     (core_a_out),
        .core_b_out     (core_b_out),
        .core_op_out    (core_op_out),
        .core_result_in (core_result_in),
        .core_carry_in  (core_carry_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_ready_in   (rsp_ready_in),
        .rsp_result_out (rsp_result_out),
        .rsp_carry_out  (rsp_carry_out),
        .rsp_zero_out   (rsp_zero_out),
        .rsp_ovf_out    (rsp_ovf_out),
        .rsp_tag_out    (rsp_tag_out),
        .busy_out       (busy_out)
    );

    // Add/sub core: subtraction is a + ~b + 1, and the carry is taken from bit 16.
    assign {core_carry_in, core_result_in} = core_op_out ?
        ({1'b0, core_a_out} + {1'b0, ~core_b_out} + 17'd1) :
        ({1'b0, core_a_out} + {1'b0, core_b_out});

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [22:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic op, input logic [3:0] tag);
        logic [16:0] s;
        logic        ov;
        s  = op ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
        ov = op ? ((a[15] != b[15]) && (s[15] != a[15])) :
                  ((a[15] == b[15]) && (s[15] != a[15]));
        return {s[15:0], s[16], (s[15:0] == 16'd0), ov, tag};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end else begin
            passed++;
        end
    endtask

    // Called just after a rising edge. Holds the request until it is accepted
    // or the cycle budget runs out.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic op, input logic [3:0] tag, input int max_wait);
        logic got;
        got          = 1'b0;
        req_a_in     = a;
        req_b_in     = b;
        req_op_in    = op;
        req_tag_in   = tag;
        req_valid_in = 1'b1;
        for (int k = 0; k < max_wait; k++) begin
            @(negedge clk_in);
            got = req_ready_out;
            @(posedge clk_in);
            #1;
            if (got) break;
        end
        req_valid_in = 1'b0;
        if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor: pop/compare responses, then record accepted requests.
    always @(negedge clk_in) begin
        if (rsp_valid_out && rsp_ready_in) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                checkOutput("sb_rsp", {9'd0, rsp_result_out, rsp_carry_out, rsp_zero_out,
                                       rsp_ovf_out, rsp_tag_out}, {9'd0, sb.pop_front()});
            end
        end
        if (rst_n_in && req_valid_in && req_ready_out) begin
            sb.push_back(model(req_a_in, req_b_in, req_op_in, req_tag_in));
        end
    end

    task automatic runLatency(input int i);
        applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, 4);
        @(negedge clk_in);
        checkOutput("lat_early_valid", {31'd0, rsp_valid_out}, 32'd0);
        @(negedge clk_in);
        checkOutput("lat_valid", {31'd0, rsp_valid_out}, 32'd1);
        checkOutput("vec_result", {16'd0, rsp_result_out}, {16'd0, vecs[i].exp_result});
        checkOutput("vec_carry", {31'd0, rsp_carry_out}, {31'd0, vecs[i].exp_carry});
        checkOutput("vec_zero", {31'd0, rsp_zero_out}, {31'd0, vecs[i].exp_zero});
        checkOutput("vec_ovf", {31'd0, rsp_ovf_out}, {31'd0, vecs[i].exp_ovf});
        checkOutput("vec_tag", {28'd0, rsp_tag_out}, {28'd0, vecs[i].tag});
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waited;
        checks       = 0;
        passed       = 0;
        rst_n_in     = 1'b0;
        req_valid_in = 1'b0;
        req_a_in     = '0;
        req_b_in     = '0;
        req_op_in    = 1'b0;
        req_tag_in   = '0;
        rsp_ready_in = 1'b1;

        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 4'd3, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h0005, 16'h0005, 1'b1, 4'd1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 4'd5, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 4'd7, 16'h7FFF, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0003, 16'h0005, 1'b1, 4'd9, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 4'd2, 16'h0000, 1'b1, 1'b1, 1'b1};

        // Reset state.
        #12;
        checkOutput("rst_req_ready", {31'd0, req_ready_out}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid_out}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_out}, 32'd0);
        checkOutput("rst_rsp_data", {9'd0, rsp_result_out, rsp_carry_out, rsp_zero_out,
                                     rsp_ovf_out, rsp_tag_out}, 32'd0);
        checkOutput("rst_core_ports", {15'd0, core_a_out, core_op_out}, 32'd0);
        checkOutput("rst_core_b", {16'd0, core_b_out}, 32'd0);
        #10;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Directed vectors with 2-cycle latency.
        for (int i = 0; i < 6; i++) begin
            runLatency(i);
        end

        // Back-pressure: 5 accepted, the 6th stalls, core ports frozen.
        rsp_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h1000 + 16'(i), 16'h0100 * 16'(i), i[0], i[3:0], 2);
        end
        req_a_in     = 16'h2222;
        req_b_in     = 16'h1111;
        req_op_in    = 1'b1;
        req_tag_in   = 4'd5;
        req_valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            checkOutput("bp_req_ready", {31'd0, req_ready_out}, 32'd0);
            checkOutput("bp_core_a", {16'd0, core_a_out}, 32'h1004);
            checkOutput("bp_core_b", {16'd0, core_b_out}, 32'h0400);
            checkOutput("bp_head_tag", {28'd0, rsp_tag_out}, 32'd0);
        end
        @(posedge clk_in);
        #1;
        rsp_ready_in = 1'b1;
        @(negedge clk_in);
        checkOutput("full_pushpop_ready", {31'd0, req_ready_out}, 32'd1);
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
        @(negedge clk_in);
        checkOutput("after_pushpop_valid", {31'd0, rsp_valid_out}, 32'd1);
        checkOutput("after_pushpop_tag", {28'd0, rsp_tag_out}, 32'd1);
        waited = 0;
        while ((sb.size() != 0 || busy_out) && waited < 20) begin
            @(negedge clk_in);
            waited++;
        end
        checkOutput("bp_drain_done", {31'd0, busy_out}, 32'd0);
        @(posedge clk_in);
        #1;

        // Streaming: 32 back-to-back random requests.
        for (int i = 0; i < 32; i++) begin
            req_a_in     = 16'($urandom);
            req_b_in     = 16'($urandom);
            req_op_in    = 1'($urandom);
            req_tag_in   = i[3:0];
            req_valid_in = 1'b1;
            @(negedge clk_in);
            checkOutput("stream_ready", {31'd0, req_ready_out}, 32'd1);
            if (i >= 2) checkOutput("stream_rsp_valid", {31'd0, rsp_valid_out}, 32'd1);
            @(posedge clk_in);
            #1;
        end
        req_valid_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            checkOutput("stream_tail_valid", {31'd0, rsp_valid_out}, 32'd1);
        end
        @(negedge clk_in);
        checkOutput("stream_sb_empty", sb.size(), 32'd0);
        @(posedge clk_in);
        #1;

        // Reset mid-stream with 3 FIFO entries and the issue stage occupied.
        rsp_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h0040 + 16'(i), 16'h0003, 1'b0, 4'(8 + i), 2);
        end
        checkOutput("pre_rst_busy", {30'd0, busy_out, rsp_valid_out}, 32'd3);
        #2;
        rst_n_in = 1'b0;
        sb.delete();
        #1;
        checkOutput("midrst_rsp_valid", {31'd0, rsp_valid_out}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy_out}, 32'd0);
        checkOutput("midrst_core_a", {16'd0, core_a_out}, 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        #2;
        rst_n_in     = 1'b1;
        rsp_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        runLatency(0);

        @(negedge clk_in);
        checkOutput("final_sb_empty", sb.size(), 32'd0);
        checkOutput("final_idle", {31'd0, busy_out}, 32'd0);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
